// File: rtl/branch_target_buffer_if.sv
// Fetch/execute-facing bundle of the branch target buffer: lookup request,
// registered response, resolved-branch update and the flush strobe.
interface branch_target_buffer_if #(
  parameter int PC_W = 32
);
  logic            flush;
  logic            lookup_valid;
  logic [PC_W-1:0] lookup_pc;
  logic            resp_valid;
  logic            resp_hit;
  logic            resp_taken;
  logic [PC_W-1:0] resp_target;
  logic            update_valid;
  logic [PC_W-1:0] update_pc;
  logic [PC_W-1:0] update_target;
  logic            update_taken;

  // Pipeline side: issues lookups/updates, consumes responses.
  modport master (
    output flush, lookup_valid, lookup_pc, update_valid, update_pc, update_target, update_taken,
    input  resp_valid, resp_hit, resp_taken, resp_target
  );

  modport slave (
    input  flush, lookup_valid, lookup_pc, update_valid, update_pc, update_target, update_taken,
    output resp_valid, resp_hit, resp_taken, resp_target
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter
// per entry; one-cycle registered lookup, read-before-write against updates.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_target_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (ctr == 2'b11) nxt = 2'b11;
      else              nxt = ctr + 2'b01;
    end else begin
      if (ctr == 2'b00) nxt = 2'b00;
      else              nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

  logic [ENTRIES-1:0]      valid_q, valid_d;
  logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
  logic [TAG_W-1:0]        tag_q [ENTRIES];
  logic [PC_W-1:0]         tgt_q [ENTRIES];

  logic            resp_valid_q, resp_valid_d;
  logic            resp_hit_q, resp_hit_d;
  logic            resp_taken_q, resp_taken_d;
  logic [PC_W-1:0] resp_target_q, resp_target_d;

  logic [IDX_W-1:0] lk_idx_s, up_idx_s;
  logic [TAG_W-1:0] lk_tag_s, up_tag_s;
  logic             lk_hit_s, up_hit_s, store_we_s;
  logic             unused_pc_bits_s;

  assign lk_idx_s = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag_s = bus.lookup_pc[PC_W-1:IDX_W+2];
  assign up_idx_s = bus.update_pc[IDX_W+1:2];
  assign up_tag_s = bus.update_pc[PC_W-1:IDX_W+2];
  assign unused_pc_bits_s = ^{bus.lookup_pc[1:0], bus.update_pc[1:0]};

  assign lk_hit_s   = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
  assign up_hit_s   = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
  // Any taken update writes tag and target: refresh on hit, allocate on miss.
  assign store_we_s = !bus.flush && bus.update_valid && bus.update_taken;

  // Next valid/counter state; flush wins over a concurrent update.
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    if (bus.flush) begin
      valid_d = {ENTRIES{1'b0}};
    end else if (bus.update_valid) begin
      if (up_hit_s) begin
        ctr_d[up_idx_s] = ctr_step(ctr_q[up_idx_s], bus.update_taken);
      end else if (bus.update_taken) begin
        valid_d[up_idx_s] = 1'b1;
        ctr_d[up_idx_s]   = 2'b10;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Response uses pre-update contents, so same-cycle updates are not visible.
  always_comb begin
    resp_valid_d  = bus.lookup_valid && !bus.flush;
    resp_hit_d    = resp_valid_d && lk_hit_s;
    resp_taken_d  = resp_hit_d && ctr_q[lk_idx_s][1];
    if (resp_hit_d) begin
      resp_target_d = tgt_q[lk_idx_s];
    end else begin
      resp_target_d = {PC_W{1'b0}};
    end
  end

  // Control state and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= {ENTRIES{1'b0}};
      ctr_q         <= {ENTRIES{2'b01}};
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_taken_q  <= 1'b0;
      resp_target_q <= {PC_W{1'b0}};
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_taken_q  <= resp_taken_d;
      resp_target_q <= resp_target_d;
    end
  end

  // Tag/target storage is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (store_we_s) begin
      tag_q[up_idx_s] <= up_tag_s;
      tgt_q[up_idx_s] <= bus.update_target;
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_hit    = resp_hit_q;
  assign bus.resp_taken  = resp_taken_q;
  assign bus.resp_target = resp_target_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized checks of branch_target_buffer against an array-based
// reference model that works on word addresses with plain integer arithmetic.
module tb_branch_target_buffer;
  localparam int ENT = 16;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  branch_target_buffer_if #(.PC_W(32)) bus ();

  branch_target_buffer #(.ENTRIES(ENT), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one slot per (word address mod ENT), tag = the rest.
  bit          m_valid [ENT];
  bit [31:0]   m_tag   [ENT];
  bit [31:0]   m_tgt   [ENT];
  int          m_ctr   [ENT];

  function automatic int idx_of(input bit [31:0] pc);
    return int'((pc / 32'd4) % ENT);
  endfunction

  function automatic bit [31:0] tag_of(input bit [31:0] pc);
    return pc / (32'd4 * ENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then check the response.
  task automatic step(input bit lv, input bit [31:0] lpc, input bit uv, input bit [31:0] upc,
                      input bit [31:0] utgt, input bit ut, input bit fl);
    int        li, ui;
    bit        e_valid, e_hit, e_taken;
    bit [31:0] e_target;
    bus.lookup_valid  = lv;
    bus.lookup_pc     = lpc;
    bus.update_valid  = uv;
    bus.update_pc     = upc;
    bus.update_target = utgt;
    bus.update_taken  = ut;
    bus.flush         = fl;
    li       = idx_of(lpc);
    e_valid  = lv && !fl;
    e_hit    = e_valid && m_valid[li] && (m_tag[li] == tag_of(lpc));
    e_taken  = e_hit && (m_ctr[li] >= 2);
    e_target = e_hit ? m_tgt[li] : 32'd0;
    if (fl) begin
      for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      ui = idx_of(upc);
      if (m_valid[ui] && m_tag[ui] == tag_of(upc)) begin
        if (ut) begin
          m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          m_tgt[ui] = utgt;
        end else begin
          m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[ui] = 1'b1;
        m_tag[ui]   = tag_of(upc);
        m_tgt[ui]   = utgt;
        m_ctr[ui]   = 2;
      end
    end
    @(posedge clk);
    #1;
    chk("resp_valid", bus.resp_valid, e_valid);
    chk("resp_hit", bus.resp_hit, e_hit);
    chk("resp_taken", bus.resp_taken, e_taken);
    chk("resp_target", bus.resp_target, e_target);
  endtask

  task automatic lookup(input bit [31:0] pc);
    step(1'b1, pc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic update(input bit [31:0] pc, input bit [31:0] tgt, input bit taken);
    step(1'b0, 32'd0, 1'b1, pc, tgt, taken, 1'b0);
  endtask

  initial begin
    bit [31:0] rpc, upc;
    rst_n = 1'b0;
    model_reset();
    bus.flush = 1'b0;
    bus.lookup_valid = 1'b1;
    bus.lookup_pc = 32'h8000_0000;
    bus.update_valid = 1'b0;
    bus.update_pc = 32'd0;
    bus.update_target = 32'd0;
    bus.update_taken = 1'b0;

    // Reset held with lookups active.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.resp_valid, 32'd0);
    chk("rst_hit", bus.resp_hit, 32'd0);
    chk("rst_taken", bus.resp_taken, 32'd0);
    chk("rst_target", bus.resp_target, 32'd0);
    rst_n = 1'b1;
    lookup(32'h8000_0000);
    chk("first_lookup_valid", bus.resp_valid, 32'd1);
    chk("first_lookup_hit", bus.resp_hit, 32'd0);

    // Allocate then hit.
    update(32'h8000_0000, 32'h8000_1234, 1'b1);
    lookup(32'h8000_0000);
    chk("alloc_hit", bus.resp_hit, 32'd1);
    chk("alloc_taken", bus.resp_taken, 32'd1);
    chk("alloc_target", bus.resp_target, 32'h8000_1234);

    // Counter saturation at 0, target retained, then climb back to taken.
    update(32'h8000_0004, 32'h8000_2000, 1'b1);
    repeat (3) update(32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
    lookup(32'h8000_0004);
    chk("sat_hit", bus.resp_hit, 32'd1);
    chk("sat_taken", bus.resp_taken, 32'd0);
    chk("sat_target", bus.resp_target, 32'h8000_2000);
    repeat (2) update(32'h8000_0004, 32'h8000_2000, 1'b1);
    lookup(32'h8000_0004);
    chk("sat_retaken", bus.resp_taken, 32'd1);

    // Same-cycle lookup and allocating update: read-before-write.
    step(1'b1, 32'h8000_0008, 1'b1, 32'h8000_0008, 32'h8000_3000, 1'b1, 1'b0);
    chk("rbw_hit", bus.resp_hit, 32'd0);
    lookup(32'h8000_0008);
    chk("rbw_next_hit", bus.resp_hit, 32'd1);
    chk("rbw_next_target", bus.resp_target, 32'h8000_3000);

    // Aliasing on index 4, then flush that drops a pending update.
    update(32'h8000_0010, 32'h8000_4000, 1'b1);
    update(32'h8000_0050, 32'h8000_5000, 1'b1);
    lookup(32'h8000_0010);
    chk("alias_evicted", bus.resp_hit, 32'd0);
    step(1'b1, 32'h8000_0050, 1'b1, 32'h8000_0050, 32'h8000_5555, 1'b1, 1'b1);
    chk("flush_resp_valid", bus.resp_valid, 32'd0);
    lookup(32'h8000_0050);
    chk("flush_dropped_update", bus.resp_hit, 32'd0);

    // Randomized traffic over 3 tags x 16 indices.
    for (int n = 0; n < 300; n++) begin
      rpc = 32'h8000_0000 + 32'($urandom_range(0, 47)) * 32'd4 + 32'($urandom_range(0, 3));
      upc = 32'h8000_0000 + 32'($urandom_range(0, 47)) * 32'd4;
      step(1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 1)), upc, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end

    // Asynchronous reset between edges.
    update(32'h8000_0100, 32'h8000_AAAA, 1'b1);
    lookup(32'h8000_0100);
    chk("pre_areset_hit", bus.resp_hit, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", bus.resp_valid, 32'd0);
    chk("areset_hit", bus.resp_hit, 32'd0);
    chk("areset_taken", bus.resp_taken, 32'd0);
    chk("areset_target", bus.resp_target, 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    lookup(32'h8000_0100);
    chk("post_areset_miss", bus.resp_hit, 32'd0);
    lookup(32'h8000_0000);
    chk("post_areset_miss2", bus.resp_hit, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
